mbs_mem_responder: RTL and testbench
====================================

Name: mbs_mem_responder

Overview:
- Bus-target side of the CPU data-memory interface: accepts the controller's level-style read/write strobes and performs one device access per strobe episode.
- Drives a handshaked word-wide device port and returns read data with a ready pulse.
- Holds the CPU in its WAIT state via `pause` while an access is outstanding.
- Sits between the core controller/datapath and data SRAM or peripherals.

Parameters:
- ADDR_WIDTH, 32, CPU byte-address width.
- DATA_WIDTH, 32, data word width.
- MEM_BASE, 32'h0000_0000, first valid byte address.
- MEM_SIZE, 4096, window size in bytes; power of two, at least 4.
- TIMEOUT, 255, maximum device wait cycles; used only with MBS_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_re  in  1  read strobe, level; may stay high for several cycles.
- cpu_we  in  1  write strobe, level.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_rdata  out  DATA_WIDTH  last completed read data, held between reads.
- cpu_rdy  out  1  one-cycle pulse when an access completes.
- pause  out  1  stall request to the core controller.
- bus_err  out  1  one-cycle pulse, coincident with cpu_rdy, when an access is rejected or aborted.
- dev_cs  out  1  device select; held until dev_ack.
- dev_we  out  1  device write enable; valid while dev_cs is high.
- dev_addr  out  ADDR_WIDTH-2  word offset, (cpu_addr-MEM_BASE)>>2.
- dev_wdata  out  DATA_WIDTH  write data captured at acceptance.
- dev_rdata  in  DATA_WIDTH  read data, valid in the dev_ack cycle.
- dev_ack  in  1  device completion, sampled only while dev_cs is high.

Behaviour:
- Reset (async, immediate): state IDLE; cpu_rdata=0; cpu_rdy=0; pause=0; bus_err=0; dev_cs=0; dev_we=0; dev_addr=0; dev_wdata=0; timeout counter=0.
- States:
  - IDLE: if (cpu_re|cpu_we) is high, capture addr/wdata/dir, then go to REQ when the access is legal, else go to RESP with an error pending.
  - REQ: dev_cs=1, pause=1; on dev_ack go to RESP.
  - RESP: cpu_rdy=1, bus_err=pending error, pause=0; next state is HOLD.
  - HOLD: stay until cpu_re=0 and cpu_we=0, then go to IDLE.
- Outputs: all outputs are registered. pause rises in the cycle after acceptance and falls in the RESP cycle.
- Latency: strobe seen at cycle 0; dev_cs high from cycle 1; dev_ack at cycle k (k≥1); cpu_rdy and the cpu_rdata update at cycle k+1.
- Read data: cpu_rdata loads dev_rdata only on a successful read and is unchanged on writes and errors.
- Strobe episodes: exactly one access per continuous strobe episode. Strobes still high after completion are ignored; HOLD enforces this.
- Illegal access (no device cycle, dev_cs stays 0, error pulse):
  - address outside [MEM_BASE, MEM_BASE+MEM_SIZE);
  - cpu_addr[1:0]≠0;
  - cpu_re and cpu_we high together at acceptance.
- Strobe dropping during REQ: the access still completes, because the device is committed.
- Address: the upper bound is compared with full-width arithmetic, with no wrap. An address that overflows past the top of the address space is out of range.
- dev_ack outside REQ: ignored.
- Reset mid-REQ: dev_cs drops asynchronously and the outstanding access is abandoned.

Optional Feature:
- Macro MBS_BUS_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to REQ and increments each REQ cycle without dev_ack.
  - When the count reaches TIMEOUT, dev_cs drops next cycle and the state goes to RESP with bus_err=1. cpu_rdata is unchanged.
  - dev_ack arriving in the same cycle as the timeout wins, giving normal completion.
- Undefined: no counter; REQ waits indefinitely for dev_ack.

Decomposition:
- Package mbs_bus_pkg: state encoding (IDLE, REQ, RESP, HOLD, 2 bits) and error-cause constants (ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_BOTH, ERR_TIMEOUT).
- Sub-module mbs_addr_decode: combinational range, alignment and offset check, producing legal, err_cause and word offset. It is reused by future peripheral targets.

Test Plan:
- Read, wait state: cpu_re=1 with addr 0x10 held 3 cycles; dev_ack 2 cycles after dev_cs with dev_rdata=0xDEADBEEF. Expect dev_addr=4, dev_we=0, pause high 2 cycles, then a single cpu_rdy pulse, cpu_rdata=0xDEADBEEF, and no second access while cpu_re stays high.
- Write: cpu_we=1, addr 0x20, wdata 0x12345678, dev_ack at the first dev_cs cycle. Expect dev_we=1, dev_wdata=0x12345678, dev_addr=8, cpu_rdy one cycle later, cpu_rdata unchanged.
- Errors:
  - addr 0x1002 expects an ALIGN error; addr 0x1000 with MEM_SIZE=4096 expects a RANGE error.
  - re and we high together expect a BOTH error.
  - In all three: dev_cs never asserts; cpu_rdy and bus_err pulse together 1 cycle after acceptance.
- Back-to-back: read episode, strobes low for 1 cycle, then a write episode. Expect exactly two device accesses and two cpu_rdy pulses.
- Reset mid-access: assert rst while in REQ. Expect dev_cs=0 and pause=0 immediately and all outputs at reset values. After release, a new read completes normally.
- Timeout (macro on, TIMEOUT=4): never ack. Expect dev_cs high 4 cycles, then a bus_err+cpu_rdy pulse. Repeat with dev_ack on the 4th cycle and expect normal completion with no error.

Source files
------------

// File: rtl/mbs_bus_pkg.sv
// Shared definitions for the memory-bus responder family.
// Provides the responder state encoding and the access error-cause codes
// reported by address decoders.
package mbs_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_RANGE   = 3'd1,
    ERR_ALIGN   = 3'd2,
    ERR_BOTH    = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_t;

endpackage

// File: rtl/mbs_addr_decode.sv
// Combinational access check for a memory-mapped target window.
// Ports:
//   addr      in   byte address
//   re, we    in   read / write strobes
//   legal     out  access may be issued to the device
//   err_cause out  reason an access is rejected (ERR_NONE when legal)
//   offset    out  word offset of addr from MEM_BASE
module mbs_addr_decode
  import mbs_bus_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  MEM_BASE   = '0,
  parameter int unsigned            MEM_SIZE   = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  re,
  input  logic                  we,
  output logic                  legal,
  output err_t                  err_cause,
  output logic [ADDR_WIDTH-3:0] offset
);

  // One extra bit so the window end cannot wrap past the top of the space.
  typedef logic [ADDR_WIDTH:0] ext_t;
  localparam ext_t LIMIT = ext_t'(MEM_BASE) + ext_t'(MEM_SIZE);

  logic in_range;

  always_comb begin
    in_range = (ext_t'(addr) >= ext_t'(MEM_BASE)) && (ext_t'(addr) < LIMIT);
    if (re && we)
      err_cause = ERR_BOTH;
    else if (addr[1:0] != 2'b00)
      err_cause = ERR_ALIGN;
    else if (!in_range)
      err_cause = ERR_RANGE;
    else
      err_cause = ERR_NONE;
    legal  = (err_cause == ERR_NONE);
    // MEM_BASE is word aligned, so subtracting the word parts is exact.
    offset = addr[ADDR_WIDTH-1:2] - MEM_BASE[ADDR_WIDTH-1:2];
  end

endmodule

// File: rtl/mbs_mem_responder.sv
// Bus-target side of the CPU data-memory interface. Each continuous
// read/write strobe episode produces exactly one device access (or one
// error response); pause stalls the core while the device is busy.
// Optional feature: define MBS_BUS_TIMEOUT_EN to abort device accesses
// that see no dev_ack within TIMEOUT cycles.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cpu_re, cpu_we    level strobes from the core controller
//   cpu_addr          byte address
//   cpu_wdata         write data
//   cpu_rdata         last completed read data
//   cpu_rdy           one-cycle completion pulse
//   pause             stall request while an access is outstanding
//   bus_err           error pulse, coincident with cpu_rdy
//   dev_cs/dev_we     device select / write enable
//   dev_addr          word offset into the device window
//   dev_wdata         write data captured at acceptance
//   dev_rdata/dev_ack device read data and completion
module mbs_mem_responder
  import mbs_bus_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  MEM_BASE   = 32'h0000_0000,
  parameter int unsigned            MEM_SIZE   = 4096,
  parameter int unsigned            TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rdy,
  output logic                  pause,
  output logic                  bus_err,
  output logic                  dev_cs,
  output logic                  dev_we,
  output logic [ADDR_WIDTH-3:0] dev_addr,
  output logic [DATA_WIDTH-1:0] dev_wdata,
  input  logic [DATA_WIDTH-1:0] dev_rdata,
  input  logic                  dev_ack
);

  state_t                  state;
  logic                    legal;
  err_t                    err_cause;
  logic [ADDR_WIDTH-3:0]   offset;

`ifdef MBS_BUS_TIMEOUT_EN
  localparam int unsigned  TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]           tcnt;
`endif

  mbs_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_BASE   (MEM_BASE),
    .MEM_SIZE   (MEM_SIZE)
  ) u_decode (
    .addr      (cpu_addr),
    .re        (cpu_re),
    .we        (cpu_we),
    .legal     (legal),
    .err_cause (err_cause),
    .offset    (offset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_rdy   <= 1'b0;
      pause     <= 1'b0;
      bus_err   <= 1'b0;
      dev_cs    <= 1'b0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
`ifdef MBS_BUS_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      cpu_rdy <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_re || cpu_we) begin
            dev_addr  <= offset;
            dev_wdata <= cpu_wdata;
            dev_we    <= cpu_we;
            if (legal) begin
              state  <= REQ;
              dev_cs <= 1'b1;
              pause  <= 1'b1;
`ifdef MBS_BUS_TIMEOUT_EN
              tcnt   <= '0;
`endif
            end else begin
              // Rejected: no device cycle, respond straight away.
              state   <= RESP;
              cpu_rdy <= 1'b1;
              bus_err <= (err_cause != ERR_NONE);
            end
          end
        end
        REQ: begin
          // The device is committed; strobes are not looked at here.
          if (dev_ack) begin
            state   <= RESP;
            dev_cs  <= 1'b0;
            pause   <= 1'b0;
            cpu_rdy <= 1'b1;
            if (!dev_we)
              cpu_rdata <= dev_rdata;
          end
`ifdef MBS_BUS_TIMEOUT_EN
          else if (tcnt == TCNT_LAST) begin
            state   <= RESP;
            dev_cs  <= 1'b0;
            pause   <= 1'b0;
            cpu_rdy <= 1'b1;
            bus_err <= 1'b1;
            tcnt    <= tcnt + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RESP: state <= HOLD;
        HOLD: begin
          if (!cpu_re && !cpu_we)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbs_mem_responder.sv
module tb_mbs_mem_responder;

  localparam longint unsigned BASE = 64'h0;
  localparam longint unsigned SIZE = 4096;
  localparam int              TO   = 4;
`ifdef MBS_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_rdy, pause, bus_err;
  logic        dev_cs, dev_we;
  logic [29:0] dev_addr;
  logic [31:0] dev_wdata, dev_rdata;
  logic        dev_ack;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdata;

  mbs_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_BASE   (32'h0000_0000),
    .MEM_SIZE   (4096),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .pause     (pause),
    .bus_err   (bus_err),
    .dev_cs    (dev_cs),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ack   (dev_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One strobe episode. d = dev_cs cycles before the ack cycle (-1: never ack),
  // hold = number of accepting edges the strobe stays high for (>=1).
  task automatic run_access(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int d, input int hold,
                            input logic [31:0] rdv);
    longint unsigned a64;
    logic            legal, exp_err;
    int              exp_cs, exp_rdy;
    int              cs_n, pause_n, rdy_n, err_n, rdy_at, end_c;
    logic            err_at_rdy;
    logic [31:0]     off;

    a64   = longint'(addr);
    legal = !(re && we) && (addr[1:0] == 2'b00) && (a64 >= BASE) && (a64 < BASE + SIZE);
    if (!legal) begin
      exp_cs = 0; exp_rdy = 1; exp_err = 1'b1;
    end else if (TO_EN && (d < 0 || d + 1 > TO)) begin
      exp_cs = TO; exp_rdy = TO + 1; exp_err = 1'b1;
    end else begin
      exp_cs = d + 1; exp_rdy = d + 2; exp_err = 1'b0;
    end
    off   = (addr - 32'(BASE)) >> 2;
    end_c = (exp_rdy + 1 > hold) ? exp_rdy + 1 : hold;

    @(negedge clk);
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    dev_ack = 1'b0;
    cs_n = 0; pause_n = 0; rdy_n = 0; err_n = 0; rdy_at = -1; err_at_rdy = 1'b0;

    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      if (dev_cs) begin
        cs_n++;
        if (cs_n == 1) begin
          check_eq("dev_addr", 64'(dev_addr), 64'(off[29:0]));
          check_eq("dev_we", 64'(dev_we), 64'(we));
          if (we) check_eq("dev_wdata", 64'(dev_wdata), 64'(wdata));
        end
      end
      if (pause) pause_n++;
      if (cpu_rdy) begin
        rdy_n++; rdy_at = c; err_at_rdy = bus_err;
      end
      if (bus_err) err_n++;
      if (dev_cs) dev_ack = (cs_n == d + 1);
      else        dev_ack = ($urandom_range(0, 3) == 0);
      dev_rdata = dev_ack ? rdv : $urandom();
      if (c >= hold) begin
        cpu_re = 1'b0; cpu_we = 1'b0;
      end
    end
    dev_ack = 1'b0;

    if (legal && re && !exp_err) model_rdata = rdv;
    check_eq("cs_cycles", 64'(cs_n), 64'(exp_cs));
    check_eq("pause_cycles", 64'(pause_n), 64'(exp_cs));
    check_eq("rdy_count", 64'(rdy_n), 64'd1);
    check_eq("rdy_cycle", 64'(rdy_at), 64'(exp_rdy));
    check_eq("err_count", 64'(err_n), 64'(exp_err));
    check_eq("err_at_rdy", 64'(err_at_rdy), 64'(exp_err));
    check_eq("cpu_rdata", 64'(cpu_rdata), 64'(model_rdata));
  endtask

  initial begin
    int           k, dmax;
    logic         re, we;
    logic [31:0]  a;

    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_rdata = '0; dev_ack = 1'b0; model_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rdata", 64'(cpu_rdata), 64'd0);
    check_eq("rst_rdy", 64'(cpu_rdy), 64'd0);
    check_eq("rst_pause", 64'(pause), 64'd0);
    check_eq("rst_err", 64'(bus_err), 64'd0);
    check_eq("rst_cs", 64'(dev_cs), 64'd0);
    check_eq("rst_addr", 64'(dev_addr), 64'd0);
    rst = 1'b0;

    // Read with a wait state, strobe held well past completion.
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 6, 32'hDEADBEEF);
    // Write acked in the first dev_cs cycle.
    run_access(1'b0, 1'b1, 32'h20, 32'h12345678, 0, 2, 32'hA5A5A5A5);
    // Rejected accesses.
    run_access(1'b1, 1'b0, 32'h1002, 32'h0, 0, 3, 32'h1);
    run_access(1'b1, 1'b0, 32'h1000, 32'h0, 0, 3, 32'h2);
    run_access(1'b1, 1'b1, 32'h40, 32'h5, 0, 3, 32'h3);
    run_access(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, 2, 32'h4);
    // Last word of the window.
    run_access(1'b1, 1'b0, 32'hFFC, 32'h0, 0, 1, 32'hCAFEF00D);
    // Back-to-back episodes with a single low cycle between them.
    run_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 4, 32'h13579BDF);
    run_access(1'b0, 1'b1, 32'h48, 32'h0BADF00D, 2, 1, 32'h77);

    // Reset while the device is selected.
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 32'h30; dev_ack = 1'b0;
    @(negedge clk);
    check_eq("midrst_cs_before", 64'(dev_cs), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_cs", 64'(dev_cs), 64'd0);
    check_eq("midrst_pause", 64'(pause), 64'd0);
    check_eq("midrst_rdata", 64'(cpu_rdata), 64'd0);
    check_eq("midrst_rdy", 64'(cpu_rdy), 64'd0);
    check_eq("midrst_addr", 64'(dev_addr), 64'd0);
    cpu_re = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    run_access(1'b1, 1'b0, 32'h30, 32'h0, 1, 2, 32'h2468ACE0);

    if (TO_EN) begin
      run_access(1'b1, 1'b0, 32'h50, 32'h0, -1, 2, 32'h99);
      run_access(1'b1, 1'b0, 32'h54, 32'h0, TO - 1, 2, 32'h600DCAFE);
      run_access(1'b0, 1'b1, 32'h58, 32'h1, -1, 8, 32'h0);
    end

    dmax = TO_EN ? 2 : 5;
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 9);
      re = 1'b0; we = 1'b0;
      case ($urandom_range(0, 6))
        0:       begin re = 1'b1; we = 1'b1; end
        1, 2, 3: re = 1'b1;
        default: we = 1'b1;
      endcase
      case (k)
        6:       a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        7:       a = 32'h1000 + {$urandom_range(0, 32'h3FFF_0000), 2'b00};
        8:       a = 32'hFFFF_FFFC;
        9:       a = 32'hFFC;
        default: a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      run_access(re, we, a, $urandom(), $urandom_range(0, dmax),
                 $urandom_range(1, 8), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
